// File: rtl/pulse_issue.sv
// Multi-channel timed pulse issue unit: per-channel command FIFOs fire their head when qclk_in reaches its time.
// Optional build macro PULSE_ISSUE_LATE_FIRE_EN: late heads fire (fields update, cstrobe pulses) instead of being dropped.
module pulse_issue #(
  parameter int DATA_WIDTH       = 32,
  parameter int ENV_WORD_WIDTH   = 24,
  parameter int PHASE_WORD_WIDTH = 14,
  parameter int FREQ_WORD_WIDTH  = 24,
  parameter int AMP_WORD_WIDTH   = 16,
  parameter int N_CHAN           = 2,
  parameter int QUEUE_DEPTH      = 4,
  parameter int CHAN_W           = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DATA_WIDTH-1:0]                qclk_in,
  input  logic                                 flush,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [CHAN_W-1:0]                    cmd_chan,
  input  logic [DATA_WIDTH-1:0]                cmd_time,
  input  logic [3:0]                           cmd_field_en,
  input  logic [ENV_WORD_WIDTH-1:0]            cmd_env,
  input  logic [PHASE_WORD_WIDTH-1:0]          cmd_phase,
  input  logic [FREQ_WORD_WIDTH-1:0]           cmd_freq,
  input  logic [AMP_WORD_WIDTH-1:0]            cmd_amp,
  output logic [N_CHAN*ENV_WORD_WIDTH-1:0]     env_addr_out,
  output logic [N_CHAN*PHASE_WORD_WIDTH-1:0]   phase_out,
  output logic [N_CHAN*FREQ_WORD_WIDTH-1:0]    freq_out,
  output logic [N_CHAN*AMP_WORD_WIDTH-1:0]     amp_out,
  output logic [N_CHAN-1:0]                    cstrobe_out,
  output logic [N_CHAN-1:0]                    late_out,
  output logic [N_CHAN-1:0]                    queue_empty
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH) + 1;

`ifdef PULSE_ISSUE_LATE_FIRE_EN
  localparam bit LATE_FIRE = 1'b1;
`else
  localparam bit LATE_FIRE = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_WIDTH-1:0]       t;
    logic [3:0]                  en;     // {amp, freq, phase, env}
    logic [AMP_WORD_WIDTH-1:0]   amp;
    logic [FREQ_WORD_WIDTH-1:0]  freq;
    logic [PHASE_WORD_WIDTH-1:0] phase;
    logic [ENV_WORD_WIDTH-1:0]   env;
  } cmd_t;

  cmd_t                      w_cmd;
  logic [N_CHAN-1:0]         w_full;
  logic [(1<<CHAN_W)-1:0]    w_full_pad;
  logic                      w_chan_ok;

  assign w_cmd = '{t: cmd_time, en: cmd_field_en, amp: cmd_amp,
                   freq: cmd_freq, phase: cmd_phase, env: cmd_env};

  // Out-of-range channels are accepted and dropped, so they never see a full queue.
  assign w_chan_ok = ({1'b0, cmd_chan} < (CHAN_W+1)'(N_CHAN));

  always_comb begin
    w_full_pad              = '0;
    w_full_pad[N_CHAN-1:0]  = w_full;
  end

  assign cmd_ready = !flush && !(w_chan_ok && w_full_pad[cmd_chan]);

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    cmd_t                        r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]            r_wr;
    logic [PTR_W-1:0]            r_rd;
    logic [ENV_WORD_WIDTH-1:0]   r_env;
    logic [PHASE_WORD_WIDTH-1:0] r_phase;
    logic [FREQ_WORD_WIDTH-1:0]  r_freq;
    logic [AMP_WORD_WIDTH-1:0]   r_amp;
    logic                        r_strobe;
    logic                        r_late;

    cmd_t                        w_head;
    logic [DATA_WIDTH-1:0]       w_d;
    logic                        w_push;
    logic                        w_fire;
    logic                        w_late;
    logic                        w_pop;
    logic                        w_load;

    assign queue_empty[c] = (r_wr == r_rd);
    assign w_full[c]      = (r_wr[PTR_W-1] != r_rd[PTR_W-1]) &&
                            (r_wr[PTR_W-2:0] == r_rd[PTR_W-2:0]);

    assign w_push = cmd_valid && cmd_ready && w_chan_ok && (cmd_chan == CHAN_W'(c));
    assign w_head = r_mem[r_rd[PTR_W-2:0]];

    // Modular difference read as signed: MSB set means the head's time has passed.
    assign w_d    = w_head.t - qclk_in;
    assign w_fire = !queue_empty[c] && (w_d == '0);
    assign w_late = !queue_empty[c] && w_d[DATA_WIDTH-1];
    assign w_pop  = !flush && (w_fire || w_late);
    assign w_load = !flush && (w_fire || (LATE_FIRE && w_late));

    // NOTE: queue storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr[PTR_W-2:0]] <= w_cmd;
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_wr     <= '0;
        r_rd     <= '0;
        r_env    <= '0;
        r_phase  <= '0;
        r_freq   <= '0;
        r_amp    <= '0;
        r_strobe <= 1'b0;
        r_late   <= 1'b0;
      end else if (flush) begin
        r_wr     <= '0;
        r_rd     <= '0;
        r_strobe <= 1'b0;
        r_late   <= 1'b0;
      end else begin
        if (w_push) r_wr <= r_wr + PTR_W'(1);
        if (w_pop)  r_rd <= r_rd + PTR_W'(1);
        r_strobe <= w_load;
        r_late   <= w_late;
        if (w_load) begin
          if (w_head.en[0]) r_env   <= w_head.env;
          if (w_head.en[1]) r_phase <= w_head.phase;
          if (w_head.en[2]) r_freq  <= w_head.freq;
          if (w_head.en[3]) r_amp   <= w_head.amp;
        end
      end
    end

    assign env_addr_out[c*ENV_WORD_WIDTH +: ENV_WORD_WIDTH]     = r_env;
    assign phase_out[c*PHASE_WORD_WIDTH +: PHASE_WORD_WIDTH]    = r_phase;
    assign freq_out[c*FREQ_WORD_WIDTH +: FREQ_WORD_WIDTH]       = r_freq;
    assign amp_out[c*AMP_WORD_WIDTH +: AMP_WORD_WIDTH]          = r_amp;
    assign cstrobe_out[c]                                       = r_strobe;
    assign late_out[c]                                          = r_late;
  end

endmodule

// File: tb/tb_pulse_issue.sv
// Self-checking bench for pulse_issue: queue-based reference model compared every cycle, plus directed literal checks.
// Honours PULSE_ISSUE_LATE_FIRE_EN for the late-command expectations.
module tb_pulse_issue;

  localparam int NC = 2;
  localparam int QD = 4;

  logic              clk;
  logic              reset;
  logic [31:0]       qclk_in;
  logic              flush;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [0:0]        cmd_chan;
  logic [31:0]       cmd_time;
  logic [3:0]        cmd_field_en;
  logic [23:0]       cmd_env;
  logic [13:0]       cmd_phase;
  logic [23:0]       cmd_freq;
  logic [15:0]       cmd_amp;
  logic [NC*24-1:0]  env_addr_out;
  logic [NC*14-1:0]  phase_out;
  logic [NC*24-1:0]  freq_out;
  logic [NC*16-1:0]  amp_out;
  logic [NC-1:0]     cstrobe_out;
  logic [NC-1:0]     late_out;
  logic [NC-1:0]     queue_empty;

  pulse_issue dut (
    .clk(clk), .reset(reset), .qclk_in(qclk_in), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
    .cmd_time(cmd_time), .cmd_field_en(cmd_field_en), .cmd_env(cmd_env),
    .cmd_phase(cmd_phase), .cmd_freq(cmd_freq), .cmd_amp(cmd_amp),
    .env_addr_out(env_addr_out), .phase_out(phase_out), .freq_out(freq_out),
    .amp_out(amp_out), .cstrobe_out(cstrobe_out), .late_out(late_out),
    .queue_empty(queue_empty)
  );

`ifdef PULSE_ISSUE_LATE_FIRE_EN
  localparam bit LATE_FIRE = 1'b1;
`else
  localparam bit LATE_FIRE = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] t;
    logic [3:0]  en;
    logic [23:0] env;
    logic [13:0] ph;
    logic [23:0] fr;
    logic [15:0] am;
  } cmd_t;

  cmd_t        mq [NC][$];
  logic [23:0] m_env [NC];
  logic [13:0] m_ph  [NC];
  logic [23:0] m_fr  [NC];
  logic [15:0] m_am  [NC];
  logic [NC-1:0] m_strobe;
  logic [NC-1:0] m_late;

  task automatic apply(input int c, input cmd_t e);
    if (e.en[0]) m_env[c] = e.env;
    if (e.en[1]) m_ph[c]  = e.ph;
    if (e.en[2]) m_fr[c]  = e.fr;
    if (e.en[3]) m_am[c]  = e.am;
  endtask

  always @(posedge clk) begin
    bit [NC-1:0]        full_pre;
    logic signed [31:0] d;
    cmd_t               e;
    m_strobe = '0;
    m_late   = '0;
    if (!reset) begin
      for (int c = 0; c < NC; c++) begin
        mq[c].delete();
        m_env[c] = '0; m_ph[c] = '0; m_fr[c] = '0; m_am[c] = '0;
      end
    end else if (flush) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
    end else begin
      for (int c = 0; c < NC; c++) full_pre[c] = (mq[c].size() == QD);
      for (int c = 0; c < NC; c++) begin
        if (mq[c].size() != 0) begin
          e = mq[c][0];
          d = e.t - qclk_in;
          if (d == 0) begin
            apply(c, e);
            m_strobe[c] = 1'b1;
            void'(mq[c].pop_front());
          end else if (d < 0) begin
            m_late[c] = 1'b1;
            if (LATE_FIRE) begin
              apply(c, e);
              m_strobe[c] = 1'b1;
            end
            void'(mq[c].pop_front());
          end
        end
      end
      if (cmd_valid && !full_pre[cmd_chan]) begin
        e = '{t: cmd_time, en: cmd_field_en, env: cmd_env, ph: cmd_phase, fr: cmd_freq, am: cmd_amp};
        mq[cmd_chan].push_back(e);
      end
    end
  end

  // Compare process: registered outputs settle just after the edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("cstrobe", cstrobe_out, m_strobe);
      check("late", late_out, m_late);
      for (int c = 0; c < NC; c++) begin
        check($sformatf("empty[%0d]", c), queue_empty[c], mq[c].size() == 0);
        check($sformatf("env[%0d]", c),   env_addr_out[c*24 +: 24], m_env[c]);
        check($sformatf("phase[%0d]", c), phase_out[c*14 +: 14], m_ph[c]);
        check($sformatf("freq[%0d]", c),  freq_out[c*24 +: 24], m_fr[c]);
        check($sformatf("amp[%0d]", c),   amp_out[c*16 +: 16], m_am[c]);
      end
      check("ready", cmd_ready, !flush && (mq[cmd_chan].size() < QD));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic [31:0] q);
    @(negedge clk);
    qclk_in = q;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [0:0] ch, input logic [31:0] t, input logic [3:0] en,
                      input logic [23:0] env, input logic [13:0] ph,
                      input logic [23:0] fr, input logic [15:0] am);
    cmd_valid    = 1'b1;
    cmd_chan     = ch;
    cmd_time     = t;
    cmd_field_en = en;
    cmd_env      = env;
    cmd_phase    = ph;
    cmd_freq     = fr;
    cmd_amp      = am;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; flush = 1'b0; cmd_valid = 1'b0; cmd_chan = '0; cmd_time = '0;
    cmd_field_en = '0; cmd_env = '0; cmd_phase = '0; cmd_freq = '0; cmd_amp = '0;
    qclk_in = '0;

    // Reset then idle
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_cstrobe", cstrobe_out, 2'b00);
    check("rst_late", late_out, 2'b00);
    check("rst_empty", queue_empty, 2'b11);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_freq", freq_out, 48'h0);
    reset = 1'b1;

    // Single fire on ch0 at time 100
    tick(90);
    push(0, 100, 4'b1111, 24'hABCDE1, 14'h1234, 24'h123456, 16'hBEEF);
    tick(91);
    cmd_valid = 1'b0;
    for (int q = 92; q < 100; q++) tick(q);
    tick(100);
    after_edge();
    check("fire100_strobe", cstrobe_out, 2'b01);
    check("fire100_freq", freq_out[23:0], 24'h123456);
    check("fire100_amp", amp_out[15:0], 16'hBEEF);
    check("fire100_ch1_freq", freq_out[47:24], 24'h0);
    tick(101);
    after_edge();
    check("fire100_oneshot", cstrobe_out, 2'b00);

    // Two consecutive fires on ch1; freq persists across a phase-only fire
    tick(40);
    push(1, 50, 4'b0100, 24'h0, 14'h0, 24'h00ABCD, 16'h0);
    tick(41);
    push(1, 51, 4'b0010, 24'h0, 14'h0777, 24'hFFFFFF, 16'h0);
    tick(42);
    cmd_valid = 1'b0;
    for (int q = 43; q < 50; q++) tick(q);
    tick(50);
    after_edge();
    check("ch1_fire50", cstrobe_out, 2'b10);
    check("ch1_freq50", freq_out[47:24], 24'h00ABCD);
    tick(51);
    after_edge();
    check("ch1_fire51", cstrobe_out, 2'b10);
    check("ch1_freq_hold", freq_out[47:24], 24'h00ABCD);
    check("ch1_phase51", phase_out[27:14], 14'h0777);
    tick(52);
    after_edge();
    check("ch1_idle52", cstrobe_out, 2'b00);

    // Fill ch0, check per-channel backpressure and push during pop
    for (int i = 0; i < QD; i++) begin
      tick(200);
      push(0, 300 + i, 4'b0100, 24'h0, 14'h0, 24'(i + 1), 16'h0);
    end
    tick(299);
    cmd_valid = 1'b0;
    cmd_chan  = 1'b1;
    #1 check("ready_ch1_ch0full", cmd_ready, 1'b1);
    cmd_chan  = 1'b0;
    #1 check("ready_ch0_full", cmd_ready, 1'b0);
    tick(300);
    push(0, 304, 4'b0100, 24'h0, 14'h0, 24'h000055, 16'h0);
    #1 check("ready_full_popping", cmd_ready, 1'b0);
    tick(301);
    #1 check("ready_after_fire", cmd_ready, 1'b1);
    tick(302);
    cmd_valid = 1'b0;
    tick(303);
    tick(304);
    after_edge();
    check("refire304_strobe", cstrobe_out, 2'b01);
    check("refire304_freq", freq_out[23:0], 24'h000055);
    check("refire304_empty", queue_empty[0], 1'b1);

    // Late command: time in the past, and time equal to qclk at push
    tick(20);
    push(0, 10, 4'b0100, 24'h0, 14'h0, 24'h0BADF0, 16'h0);
    tick(21);
    cmd_valid = 1'b0;
    after_edge();
    check("late10_late", late_out, 2'b01);
    check("late10_strobe", cstrobe_out, LATE_FIRE ? 2'b01 : 2'b00);
    check("late10_freq", freq_out[23:0], LATE_FIRE ? 24'h0BADF0 : 24'h000055);
    tick(30);
    push(1, 30, 4'b1000, 24'h0, 14'h0, 24'h0, 16'h7777);
    tick(31);
    cmd_valid = 1'b0;
    after_edge();
    check("late_eq_late", late_out, 2'b10);
    tick(32);
    after_edge();
    check("late_oneshot", late_out, 2'b00);

    // Flush with a simultaneous push
    for (int i = 0; i < 3; i++) begin
      tick(500);
      push(0, 600 + i, 4'b1111, 24'h111111, 14'h0222, 24'h333333, 16'h4444);
    end
    tick(500);
    flush = 1'b1;
    push(0, 603, 4'b1111, 24'h0, 14'h0, 24'h0, 16'h0);
    #1 check("flush_ready", cmd_ready, 1'b0);
    after_edge();
    check("flush_empty", queue_empty[0], 1'b1);
    tick(501);
    flush = 1'b0;
    cmd_valid = 1'b0;
    for (int q = 502; q < 600; q++) tick(q);
    tick(600);
    after_edge();
    check("flush_nostrobe", cstrobe_out, 2'b00);
    for (int q = 601; q < 606; q++) tick(q);

    // Reset mid-queue
    tick(650);
    push(1, 700, 4'b0100, 24'h0, 14'h0, 24'h777777, 16'h0);
    tick(650);
    push(1, 701, 4'b0100, 24'h0, 14'h0, 24'h888888, 16'h0);
    tick(650);
    push(0, 705, 4'b0001, 24'h999999, 14'h0, 24'h0, 16'h0);
    tick(651);
    cmd_valid = 1'b0;
    reset = 1'b0;
    after_edge();
    check("rstmid_empty", queue_empty, 2'b11);
    check("rstmid_freq", freq_out, 48'h0);
    check("rstmid_phase", phase_out, 28'h0);
    check("rstmid_amp", amp_out, 32'h0);
    check("rstmid_env", env_addr_out, 48'h0);
    tick(652);
    reset = 1'b1;
    for (int q = 653; q < 700; q++) tick(q);
    tick(700);
    after_edge();
    check("rstmid_nostrobe", cstrobe_out, 2'b00);
    for (int q = 701; q < 708; q++) tick(q);
    after_edge();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_issue.md
# pulse_issue

Multi-channel timed pulse issue unit sitting between the processor core and the DAC-side signal generators. The core pushes pulse commands, each a channel tag, trigger time and per-field write enables, into a per-channel queue ahead of time. Each channel fires its queue head when the shared qclk reaches the command time. On a fire it updates sticky freq/phase/env/amp registers and pulses cstrobe. This generalises the single-channel, zero-buffer compare-and-strobe path to N channels with queueing and late-command detection.

## Interface
- DATA_WIDTH, 32, qclk and command time width
- ENV_WORD_WIDTH, 24, envelope address word
- PHASE_WORD_WIDTH, 14, phase word
- FREQ_WORD_WIDTH, 24, frequency word
- AMP_WORD_WIDTH, 16, amplitude word
- N_CHAN, 2, channel count (≥1); CHAN_W = max(1, $clog2(N_CHAN))
- QUEUE_DEPTH, 4, entries per channel queue (power of 2, ≥2)

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-low
- qclk_in  in  DATA_WIDTH  current qclk value
- flush  in  1  discard all queued commands
- cmd_valid  in  1  command offered
- cmd_ready  out  1  = !flush & !full[cmd_chan]
- cmd_chan  in  CHAN_W  target channel
- cmd_time  in  DATA_WIDTH  qclk value at which to fire
- cmd_field_en  in  4  {amp, freq, phase, env} write enables
- cmd_env, cmd_phase, cmd_freq, cmd_amp  in  field widths  field values, already reg/immediate-muxed by the core
- env_addr_out  out  N_CHAN*ENV_WORD_WIDTH  per-channel envelope, channel c at [c*W +: W] (same packing for all per-channel buses)
- phase_out  out  N_CHAN*PHASE_WORD_WIDTH
- freq_out  out  N_CHAN*FREQ_WORD_WIDTH
- amp_out  out  N_CHAN*AMP_WORD_WIDTH
- cstrobe_out  out  N_CHAN  one-cycle fire strobe
- late_out  out  N_CHAN  one-cycle late-command pulse
- queue_empty  out  N_CHAN  channel queue empty

## Operation
- Push: cmd_valid & cmd_ready writes {time, field_en, fields} into queue[cmd_chan]. cmd_chan ≥ N_CHAN: ready high, command discarded.
- Each channel runs an independent FIFO with read/write pointers of $clog2(QUEUE_DEPTH)+1 bits. full = MSB differs & rest equal. Wrap-around is natural.
- Head evaluation per channel when non-empty: d = head.time − qclk_in, taken mod 2^DATA_WIDTH as signed.
  - d == 0: fire. Pop the head. Each field with its en bit set loads its output register; fields without it hold. cstrobe[c] = 1.
  - d < 0: late. Pop the head and set late[c] = 1; handling follows Configuration.
  - d > 0: wait.
- Simultaneous push and pop on one channel: both occur; count unchanged. ready reflects pre-pop full, so a full queue refuses the push even when popping that cycle.
- Channels are fully independent. Multiple channels may fire in the same cycle.
- flush: all pointers reset in one cycle and no fire occurs that cycle. Output field registers hold. Any push that cycle is refused.
- Reset (low): queues empty and all outputs 0. Reset mid-operation discards queued commands.

## Timing
- Push at edge N: entry is head-visible in cycle N+1. A command whose time equals qclk_in at its push cycle is therefore late.
- Fire decided in cycle N (qclk_in == time) → outputs and cstrobe registered, visible from N+1. cstrobe and late are high for exactly one cycle.
- At most one pop per channel per cycle. Back-to-back fires require consecutive times.
- All outputs are registered with no combinational path from cmd_* to outputs. The exception is cmd_ready, which is combinational from flush, cmd_chan and full.

## Configuration
- PULSE_ISSUE_LATE_FIRE_EN defined: a late head is treated as a fire with the same latency. Fields update, cstrobe pulses, and late_out pulses in the same cycle.
- Undefined: a late head is dropped. Fields hold, cstrobe stays 0, and only late_out pulses.

## Test plan
- Reset then idle: all outputs 0, queue_empty all 1, cmd_ready 1.
- Push ch0 time=100, all fields en, freq=0x123456. qclk ramps by 1. Expect cstrobe_out[0] high only in the cycle after qclk_in=100, with freq_out[0] = 0x123456. Ch1 stays idle.
- Push ch1 time=50 with freq en, then time=51 with only phase en. Expect two consecutive strobes. Freq from the first command persists through the second fire.
- Fill ch0 with QUEUE_DEPTH entries: cmd_ready low for ch0 and high for ch1. After one fire, ready returns. Simultaneous-pop push is refused only while full.
- Push ch0 time=10 while qclk_in=20: late_out[0] pulses. cstrobe and fields follow PULSE_ISSUE_LATE_FIRE_EN; run both builds.
- Queue 3 commands, then assert flush together with cmd_valid: queue_empty[0]=1, cmd_ready=0, and no strobes follow. Repeat with reset low mid-queue: same result and outputs zeroed.
